// File: rtl/cfd_trigger_multimode.sv
// Constant-fraction self-trigger for one DAPHNE channel: y = delayed(p) - p*2^-f on the
// polarity-normalised sample stream, with arm window, dead time and crossing-sample capture.
//
// state | meaning
// IDLE  | waiting for normalised sample above threshold; also held here while the line fills
// ARMED | watching y for a negative to non-negative crossing; window timer running
// DEAD  | trigger issued; input ignored for DEAD_TIME enabled samples
module cfd_trigger_multimode #(
  parameter int DATA_W     = 16,
  parameter int MAX_DELAY  = 32,
  parameter int DLY_W      = 6,
  parameter int ARM_WINDOW = 128,
  parameter int DEAD_TIME  = 64,
  parameter int CNT_W      = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     enable,
  input  logic signed [DATA_W-1:0] x,
  input  logic signed [DATA_W-1:0] threshold,
  input  logic [DLY_W-1:0]         delay_sel,
  input  logic [2:0]               frac_shift,
  input  logic                     polarity,
  output logic                     trigger,
  output logic signed [DATA_W-1:0] y,
  output logic signed [DATA_W-1:0] y_before,
  output logic signed [DATA_W-1:0] y_after,
  output logic                     armed,
  output logic                     timeout,
  output logic [CNT_W-1:0]         trig_count
);
  localparam int PTR_W  = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;
  localparam int FILL_W = $clog2(MAX_DELAY + 1);
  localparam int RD_W   = ((PTR_W > DLY_W) ? PTR_W : DLY_W) + 2;
  localparam int WIN_W  = (ARM_WINDOW > 1) ? $clog2(ARM_WINDOW) : 1;
  localparam int DEAD_W = (DEAD_TIME > 1) ? $clog2(DEAD_TIME) : 1;
  localparam logic signed [DATA_W-1:0] S_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] S_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ARMED, DEAD} state_t;
  state_t state;

  logic signed [DATA_W-1:0] thr_s;
  logic [DLY_W-1:0]         dly_s;
  logic [2:0]               fs_s;
  logic                     pol_s;

  logic signed [DATA_W-1:0] dline [MAX_DELAY];
  logic [PTR_W-1:0]         wptr;
  logic [FILL_W-1:0]        fill_cnt;
  logic                     filled;
  logic signed [DATA_W-1:0] p, p_next, p_sh, d, y_calc, y_prev;
  logic [DLY_W-1:0]         dly_eff;
  logic [RD_W-1:0]          rd_wide;
  logic [PTR_W-1:0]         rd_idx;
  logic [DATA_W:0]          diff;
  logic [WIN_W-1:0]         win_cnt;
  logic [DEAD_W-1:0]        dead_cnt;

  // configuration only follows the inputs while nothing is in flight
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      thr_s <= '0;
      dly_s <= '0;
      fs_s  <= '0;
      pol_s <= 1'b0;
    end else if (state == IDLE) begin
      thr_s <= threshold;
      dly_s <= delay_sel;
      fs_s  <= frac_shift;
      pol_s <= polarity;
    end
  end

  assign filled = (fill_cnt == FILL_W'(MAX_DELAY));

  always_comb begin
    p_next = x;
    if (pol_s) p_next = (x == S_MIN) ? S_MAX : -x;

    dly_eff = dly_s;
    if (dly_s == '0) dly_eff = DLY_W'(1);
    else if (dly_s > DLY_W'(MAX_DELAY)) dly_eff = DLY_W'(MAX_DELAY);

    // the slot about to be overwritten holds the sample MAX_DELAY back
    rd_wide = RD_W'(wptr) + RD_W'(MAX_DELAY) - RD_W'(dly_eff);
    if (rd_wide >= RD_W'(MAX_DELAY)) rd_wide = rd_wide - RD_W'(MAX_DELAY);
    rd_idx = rd_wide[PTR_W-1:0];
    d      = dline[rd_idx];

    p_sh   = p >>> fs_s;
    diff   = {d[DATA_W-1], d} - {p_sh[DATA_W-1], p_sh};
    y_calc = diff[DATA_W-1:0];
    if (diff[DATA_W] != diff[DATA_W-1]) y_calc = diff[DATA_W] ? S_MIN : S_MAX;
  end

  always_ff @(posedge clk) begin
    if (enable) dline[wptr] <= p;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p        <= '0;
      y        <= '0;
      y_prev   <= '0;
      wptr     <= '0;
      fill_cnt <= '0;
    end else if (enable) begin
      p      <= p_next;
      y      <= filled ? y_calc : '0;
      y_prev <= y;
      wptr   <= (wptr == PTR_W'(MAX_DELAY - 1)) ? '0 : wptr + PTR_W'(1);
      if (!filled) fill_cnt <= fill_cnt + FILL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      armed      <= 1'b0;
      trigger    <= 1'b0;
      timeout    <= 1'b0;
      y_before   <= '0;
      y_after    <= '0;
      trig_count <= '0;
      win_cnt    <= '0;
      dead_cnt   <= '0;
    end else begin
      trigger <= 1'b0;
      timeout <= 1'b0;
      if (enable) begin
        unique case (state)
          IDLE: begin
            if (filled && (p > thr_s)) begin
              state   <= ARMED;
              armed   <= 1'b1;
              win_cnt <= WIN_W'(ARM_WINDOW - 1);
            end
          end
          ARMED: begin
            if (y_prev[DATA_W-1] && !y[DATA_W-1]) begin
              state      <= DEAD;
              armed      <= 1'b0;
              trigger    <= 1'b1;
              y_before   <= y_prev;
              y_after    <= y;
              trig_count <= trig_count + CNT_W'(1);
              dead_cnt   <= DEAD_W'(DEAD_TIME - 1);
            end else if (win_cnt == '0) begin
              state   <= IDLE;
              armed   <= 1'b0;
              timeout <= 1'b1;
            end else begin
              win_cnt <= win_cnt - WIN_W'(1);
            end
          end
          DEAD: begin
            if (dead_cnt == '0) state <= IDLE;
            else dead_cnt <= dead_cnt - DEAD_W'(1);
          end
          default: begin
            state <= IDLE;
            armed <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_cfd_trigger_multimode.sv
// Bench for cfd_trigger_multimode: directed pulse scenarios and randomized traffic, each
// clock compared with a model that works on the per-sample history of p and y.
`timescale 1ns/1ps
module tb_cfd_trigger_multimode;
  localparam int MAXD  = 32;
  localparam int WIN   = 128;
  localparam int DEADT = 64;
  localparam int FILL  = 40;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic enable = 1'b0;
  logic signed [15:0] x = '0;
  logic signed [15:0] threshold = '0;
  logic [5:0] delay_sel = '0;
  logic [2:0] frac_shift = '0;
  logic polarity = 1'b0;
  logic trigger, armed, timeout;
  logic signed [15:0] y, y_before, y_after;
  logic [15:0] trig_count;

  always #5 clk = ~clk;

  cfd_trigger_multimode dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .x(x), .threshold(threshold),
    .delay_sel(delay_sel), .frac_shift(frac_shift), .polarity(polarity),
    .trigger(trigger), .y(y), .y_before(y_before), .y_after(y_after),
    .armed(armed), .timeout(timeout), .trig_count(trig_count)
  );

  int n_total = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model (indexed by enabled sample) ----------------
  int cfg_pol, cfg_dsel, cfg_fs, cfg_thr;
  int m_p[$], m_y[$];
  int m_mode, m_win, m_dead, m_cnt, m_yb, m_ya;
  logic m_trig, m_tmo;

  function automatic int sat16(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic int eff_delay(input int s);
    if (s == 0) return 1;
    if (s > MAXD) return MAXD;
    return s;
  endfunction

  task automatic model_reset();
    m_p = {};
    m_y = {};
    m_p.push_back(0);
    m_y.push_back(0);
    m_mode = 0; m_win = 0; m_dead = 0; m_cnt = 0; m_yb = 0; m_ya = 0;
    m_trig = 1'b0; m_tmo = 1'b0;
  endtask

  // step for enabled sample number e (1-based since reset); m_p[k]/m_y[k] are the
  // values p and y hold after sample k.
  task automatic model_step(input int xv);
    int e, pv, ynew, yo, yo2;
    bit full;
    e    = m_p.size();
    full = (e - 1) >= MAXD;
    pv   = cfg_pol ? ((xv == -32768) ? 32767 : -xv) : xv;
    ynew = 0;
    if (full) ynew = sat16(m_p[e - 1 - eff_delay(cfg_dsel)] - (m_p[e - 1] >>> cfg_fs));
    yo  = m_y[e - 1];
    yo2 = (e >= 2) ? m_y[e - 2] : 0;
    case (m_mode)
      0: if (full && m_p[e - 1] > cfg_thr) begin
           m_mode = 1;
           m_win  = 0;
         end
      1: if (yo2 < 0 && yo >= 0) begin
           m_trig = 1'b1;
           m_yb   = yo2;
           m_ya   = yo;
           m_cnt  = (m_cnt + 1) % 65536;
           m_mode = 2;
           m_dead = 0;
         end else begin
           m_win++;
           if (m_win == WIN) begin
             m_tmo  = 1'b1;
             m_mode = 0;
           end
         end
      default: begin
        m_dead++;
        if (m_dead == DEADT) m_mode = 0;
      end
    endcase
    m_p.push_back(pv);
    m_y.push_back(ynew);
  endtask

  // ---------------- stimulus helpers ----------------
  int cyc = 0;
  int st_trig, st_tmo, st_arm, first_trig_cyc, first_trig_e, first_arm_cyc, tmo_cyc, arm_at_tmo;
  int cyc_a, cyc_b, e_a, e_b;

  task automatic clr_stats();
    st_trig = 0; st_tmo = 0; st_arm = 0;
    first_trig_cyc = -1; first_trig_e = -1; first_arm_cyc = -1; tmo_cyc = -1; arm_at_tmo = -1;
  endtask

  task automatic set_cfg(input int pol, input int dsel, input int fs, input int thr);
    cfg_pol = pol; cfg_dsel = dsel; cfg_fs = fs; cfg_thr = thr;
    polarity   = pol[0];
    delay_sel  = dsel[5:0];
    frac_shift = fs[2:0];
    threshold  = thr[15:0];
  endtask

  task automatic tick(input logic en, input int xv);
    enable = en;
    x = xv[15:0];
    @(posedge clk);
    #1;
    cyc++;
    m_trig = 1'b0;
    m_tmo  = 1'b0;
    if (en) model_step(xv);
    chk("trigger", trigger, m_trig);
    chk("timeout", timeout, m_tmo);
    chk("armed", armed, (m_mode == 1));
    chk("y", y, m_y[m_y.size() - 1]);
    chk("y_before", y_before, m_yb);
    chk("y_after", y_after, m_ya);
    chk("trig_count", trig_count, m_cnt);
    if (trigger === 1'b1) begin
      if (st_trig == 0) begin
        first_trig_cyc = cyc;
        first_trig_e   = m_p.size() - 1;
      end
      st_trig++;
    end
    if (armed === 1'b1) begin
      if (st_arm == 0) first_arm_cyc = cyc;
      st_arm++;
    end
    if (timeout === 1'b1) begin
      if (st_tmo == 0) begin
        tmo_cyc    = cyc;
        arm_at_tmo = int'(armed);
      end
      st_tmo++;
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    enable  = 1'b0;
    #1;
    chk("rst_trigger", trigger, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_armed", armed, 0);
    chk("rst_y", y, 0);
    chk("rst_y_before", y_before, 0);
    chk("rst_y_after", y_after, 0);
    chk("rst_count", trig_count, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
    tick(1'b0, 0);
  endtask

  // gap: enabled every gap-th clock; rnd: random 0..gap idle clocks between samples
  task automatic run_q(input int xs[$], input int gap, input bit rnd, input int mark_a, input int mark_b);
    for (int i = 0; i < xs.size(); i++) begin
      int idle;
      idle = rnd ? int'($urandom_range(0, gap)) : gap - 1;
      for (int g = 0; g < idle; g++) tick(1'b0, xs[i]);
      if (i == mark_a) cyc_a = cyc;
      if (i == mark_b) cyc_b = cyc;
      tick(1'b1, xs[i]);
      if (i == mark_a) e_a = m_p.size() - 1;
      if (i == mark_b) e_b = m_p.size() - 1;
    end
  endtask

  // n samples, rectangular pulses of amplitude amp at s1 and s2 of length len; optional zero fill
  task automatic build(output int xs[$], input int n, input int amp, input int s1, input int s2,
                       input int len, input bit fill);
    xs = {};
    if (fill) for (int i = 0; i < FILL; i++) xs.push_back(0);
    for (int s = 0; s < n; s++)
      xs.push_back(((s >= s1 && s < s1 + len) || (s >= s2 && s < s2 + len)) ? amp : 0);
  endtask

  int xs[$];

  initial begin
    #2;
    // T2: negative pulse, nominal
    set_cfg(1, 15, 0, 100);
    do_reset();
    clr_stats();
    build(xs, 60, -1000, 10, -1000, 20, 1'b1);
    run_q(xs, 1, 1'b0, FILL + 10, FILL + 25);
    chk("t2_ntrig", st_trig, 1);
    chk("t2_latency", first_trig_cyc - cyc_b, 3);
    chk("t2_index", first_trig_e - e_b, 2);
    chk("t2_arm", first_arm_cyc - cyc_a, 2);
    chk("t2_y_before", y_before, -1000);
    chk("t2_y_after", y_after, 0);
    chk("t2_count", trig_count, 1);

    // T1: reset while armed, then the rest of the pulse
    set_cfg(1, 15, 0, 100);
    do_reset();
    clr_stats();
    build(xs, 16, -1000, 10, -1000, 20, 1'b1);
    run_q(xs, 1, 1'b0, -1, -1);
    chk("t1_armed_before_reset", armed, 1);
    do_reset();
    clr_stats();
    build(xs, 44, -1000, -6, -1000, 20, 1'b0);
    run_q(xs, 1, 1'b0, -1, -1);
    chk("t1_ntrig", st_trig, 0);
    chk("t1_count", trig_count, 0);

    // T3: sub-threshold
    set_cfg(1, 15, 0, 100);
    do_reset();
    clr_stats();
    build(xs, 60, -50, 10, -1000, 20, 1'b1);
    run_q(xs, 1, 1'b0, -1, -1);
    chk("t3_armed_seen", st_arm, 0);
    chk("t3_ntrig", st_trig, 0);
    chk("t3_count", trig_count, 0);

    // T4: ramp, y steady negative -> timeout
    set_cfg(0, 15, 0, 100);
    do_reset();
    clr_stats();
    xs = {};
    for (int i = 0; i < FILL; i++) xs.push_back(0);
    for (int s = 0; s < 180; s++) xs.push_back((s >= 10) ? 10 * s : 0);
    run_q(xs, 1, 1'b0, -1, -1);
    chk("t4_ntrig", st_trig, 0);
    chk("t4_ntimeout", st_tmo, 1);
    chk("t4_window", tmo_cyc - first_arm_cyc, WIN);
    chk("t4_idle_at_timeout", arm_at_tmo, 0);
    chk("t4_y", y, -150);

    // T5: dead time
    set_cfg(1, 15, 0, 100);
    do_reset();
    clr_stats();
    build(xs, 200, -1000, 10, 50, 20, 1'b1);
    run_q(xs, 1, 1'b0, -1, -1);
    chk("t5_close_ntrig", st_trig, 1);
    chk("t5_close_count", trig_count, 1);
    do_reset();
    clr_stats();
    build(xs, 200, -1000, 10, 110, 20, 1'b1);
    run_q(xs, 1, 1'b0, -1, -1);
    chk("t5_far_ntrig", st_trig, 2);
    chk("t5_far_count", trig_count, 2);

    // T6: gapped enable, positive pulse, f = 1/2
    set_cfg(0, 15, 1, 100);
    do_reset();
    clr_stats();
    build(xs, 60, 1000, 10, -1000, 20, 1'b1);
    run_q(xs, 4, 1'b0, FILL + 10, FILL + 25);
    chk("t6_ntrig_clks", st_trig, 1);
    chk("t6_index", first_trig_e - e_b, 2);
    chk("t6_y_before", y_before, -500);
    chk("t6_y_after", y_after, 500);
    chk("t6_count", trig_count, 1);

    // randomized traffic
    for (int seg = 0; seg < 10; seg++) begin
      set_cfg(int'($urandom_range(0, 1)), int'($urandom_range(0, 63)), int'($urandom_range(0, 7)),
              int'($urandom_range(0, 3000)) - 300);
      do_reset();
      clr_stats();
      xs = {};
      while (xs.size() < 360) begin
        int amp, len, quiet;
        quiet = int'($urandom_range(0, 70));
        for (int i = 0; i < quiet; i++) xs.push_back(int'($urandom_range(0, 40)) - 20);
        amp = int'($urandom_range(0, 20000));
        if ($urandom_range(0, 1) == 1) amp = -amp;
        len = int'($urandom_range(3, 40));
        for (int i = 0; i < len; i++) begin
          if ($urandom_range(0, 9) == 0) xs.push_back(-32768);
          else xs.push_back(sat16(amp + int'($urandom_range(0, 40)) - 20));
        end
      end
      run_q(xs, (seg % 3 == 0) ? 1 : 3, (seg % 3 != 0), -1, -1);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
